fp32_align_stage: RTL

Two-stage pipelined operand-alignment front end for the single-precision (IEEE-754 binary32) adder datapath. It takes an operand pair, orders it by magnitude, and right-shifts the smaller significand with guard/round/sticky bits. It also classifies special operands. Output goes straight into the add/normalise/round stage of `adder`. Operand pairs move on a valid/ready handshake on both sides.

---
 rtl/fp32_align_stage.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/fp32_align_stage.sv
// Two-stage operand-alignment front end for the binary32 adder.
// Stage 1 unpacks both operands, orders them by magnitude, computes the
// exponent difference and classifies NaN/Inf. Stage 2 right-shifts the
// smaller significand with a sticky bit and presents the aligned pair.
// Both stages use a valid/ready handshake with full-throughput back-pressure.

module fp32_align_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_01,
  input  logic [31:0] input_02,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign_large,
  output logic        out_sign_small,
  output logic        out_eff_sub,
  output logic [7:0]  out_exp,
  output logic [26:0] out_mant_large,
  output logic [26:0] out_mant_small,
  output logic        out_special,
  output logic [31:0] out_special_result
);

  localparam logic [31:0] QNaN      = 32'h7FC0_0000;
  localparam logic [7:0]  ExpMax    = 8'hFF;
  localparam logic [7:0]  ShiftLim  = 8'd27;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s2_load;
  logic s1_accept;

  assign s2_load   = !out_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_load;
  assign s1_accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: unpack, order, diff, specials
  // ---------------------------------------------------------------------------
  logic        sign_a, sign_b;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic        hid_a, hid_b;
  logic [7:0]  eexp_a, eexp_b;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic        b_is_large;

  logic        s1_sign_l_d, s1_sign_s_d;
  logic        s1_eff_sub_d;
  logic [7:0]  s1_exp_l_d, s1_exp_s_d;
  logic [23:0] s1_man_l_d, s1_man_s_d;
  logic [7:0]  s1_diff_d;
  logic        s1_special_d;
  logic [31:0] s1_special_result_d;

  // Field extraction and per-operand classification.
  always_comb begin
    sign_a = input_01[31];
    sign_b = input_02[31];
    exp_a  = input_01[30:23];
    exp_b  = input_02[30:23];
    frac_a = input_01[22:0];
    frac_b = input_02[22:0];

    // exp==0 is treated as exponent 1 with no hidden bit (denormal/zero).
    hid_a  = (exp_a != 8'd0);
    hid_b  = (exp_b != 8'd0);
    eexp_a = hid_a ? exp_a : 8'd1;
    eexp_b = hid_b ? exp_b : 8'd1;

    nan_a  = (exp_a == ExpMax) && (frac_a != 23'd0);
    nan_b  = (exp_b == ExpMax) && (frac_b != 23'd0);
    inf_a  = (exp_a == ExpMax) && (frac_a == 23'd0);
    inf_b  = (exp_b == ExpMax) && (frac_b == 23'd0);
  end

  // Magnitude ordering; a tie keeps input_01 as the large operand.
  always_comb begin
    b_is_large   = (input_02[30:0] > input_01[30:0]);
    s1_eff_sub_d = sign_a ^ sign_b;

    s1_sign_l_d = sign_a;
    s1_sign_s_d = sign_b;
    s1_exp_l_d  = eexp_a;
    s1_exp_s_d  = eexp_b;
    s1_man_l_d  = {hid_a, frac_a};
    s1_man_s_d  = {hid_b, frac_b};

    if (b_is_large) begin
      s1_sign_l_d = sign_b;
      s1_sign_s_d = sign_a;
      s1_exp_l_d  = eexp_b;
      s1_exp_s_d  = eexp_a;
      s1_man_l_d  = {hid_b, frac_b};
      s1_man_s_d  = {hid_a, frac_a};
    end

    // Never negative because the large operand has the larger exponent.
    s1_diff_d = s1_exp_l_d - s1_exp_s_d;
  end

  // Special classification in priority order: NaN, Inf-Inf, single Inf.
  always_comb begin
    s1_special_d        = 1'b0;
    s1_special_result_d = 32'd0;
    if (nan_a || nan_b) begin
      s1_special_d        = 1'b1;
      s1_special_result_d = QNaN;
    end else if (inf_a && inf_b && s1_eff_sub_d) begin
      s1_special_d        = 1'b1;
      s1_special_result_d = QNaN;
    end else if (inf_a) begin
      s1_special_d        = 1'b1;
      s1_special_result_d = {sign_a, ExpMax, 23'd0};
    end else if (inf_b) begin
      s1_special_d        = 1'b1;
      s1_special_result_d = {sign_b, ExpMax, 23'd0};
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic        s1_sign_l_q, s1_sign_s_q;
  logic        s1_eff_sub_q;
  logic [7:0]  s1_exp_l_q;
  logic [23:0] s1_man_l_q, s1_man_s_q;
  logic [7:0]  s1_diff_q;
  logic        s1_special_q;
  logic [31:0] s1_special_result_q;

  // Stage 1 occupancy: fill on accept, empty when drained into stage 2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_accept) begin
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 1 state; data captured only on an accepted pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q          <= 1'b0;
      s1_sign_l_q         <= 1'b0;
      s1_sign_s_q         <= 1'b0;
      s1_eff_sub_q        <= 1'b0;
      s1_exp_l_q          <= 8'd0;
      s1_man_l_q          <= 24'd0;
      s1_man_s_q          <= 24'd0;
      s1_diff_q           <= 8'd0;
      s1_special_q        <= 1'b0;
      s1_special_result_q <= 32'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_accept) begin
        s1_sign_l_q         <= s1_sign_l_d;
        s1_sign_s_q         <= s1_sign_s_d;
        s1_eff_sub_q        <= s1_eff_sub_d;
        s1_exp_l_q          <= s1_exp_l_d;
        s1_man_l_q          <= s1_man_l_d;
        s1_man_s_q          <= s1_man_s_d;
        s1_diff_q           <= s1_diff_d;
        s1_special_q        <= s1_special_d;
        s1_special_result_q <= s1_special_result_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: alignment shift with sticky
  // ---------------------------------------------------------------------------
  logic [26:0] sig_s;
  logic [26:0] shifted;
  logic [26:0] lost_mask;
  logic        sticky;
  logic [26:0] mant_small_d;

  // Shift the smaller significand; anything shifted out folds into bit 0.
  always_comb begin
    sig_s        = {s1_man_s_q, 3'b000};
    shifted      = 27'd0;
    lost_mask    = 27'd0;
    sticky       = 1'b0;
    mant_small_d = 27'd0;
    if (s1_diff_q < ShiftLim) begin
      shifted      = sig_s >> s1_diff_q;
      lost_mask    = ~({27{1'b1}} << s1_diff_q);
      sticky       = |(sig_s & lost_mask);
      mant_small_d = {shifted[26:1], shifted[0] | sticky};
    end else begin
      // Everything is shifted out; only the sticky survives.
      mant_small_d = {26'd0, |sig_s};
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers (outputs)
  // ---------------------------------------------------------------------------
  logic        out_sign_large_q, out_sign_small_q, out_eff_sub_q;
  logic [7:0]  out_exp_q;
  logic [26:0] out_mant_large_q, out_mant_small_q;
  logic        out_special_q;
  logic [31:0] out_special_result_q;

  // Output valid: reload from stage 1 whenever the output slot is free.
  always_comb begin
    out_valid_d = out_valid_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
    end
  end

  // Output fields; held while stalled so they stay stable under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q          <= 1'b0;
      out_sign_large_q     <= 1'b0;
      out_sign_small_q     <= 1'b0;
      out_eff_sub_q        <= 1'b0;
      out_exp_q            <= 8'd0;
      out_mant_large_q     <= 27'd0;
      out_mant_small_q     <= 27'd0;
      out_special_q        <= 1'b0;
      out_special_result_q <= 32'd0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s2_load && s1_valid_q) begin
        out_sign_large_q     <= s1_sign_l_q;
        out_sign_small_q     <= s1_sign_s_q;
        out_eff_sub_q        <= s1_eff_sub_q;
        out_exp_q            <= s1_exp_l_q;
        out_mant_large_q     <= {s1_man_l_q, 3'b000};
        out_mant_small_q     <= mant_small_d;
        out_special_q        <= s1_special_q;
        out_special_result_q <= s1_special_result_q;
      end
    end
  end

  assign out_valid          = out_valid_q;
  assign out_sign_large     = out_sign_large_q;
  assign out_sign_small     = out_sign_small_q;
  assign out_eff_sub        = out_eff_sub_q;
  assign out_exp            = out_exp_q;
  assign out_mant_large     = out_mant_large_q;
  assign out_mant_small     = out_mant_small_q;
  assign out_special        = out_special_q;
  assign out_special_result = out_special_result_q;

endmodule
